// File: rtl/des_pkg.sv
// Shared DES definitions for the output stage: block geometry, final permutation table, FSM states.
// Vectors are MSB-first: DES bit 1 sits in bit [W-1] of every vector.
package des_pkg;

  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned HALF_W  = 32;

  // FP[i] = preoutput bit (DES numbering from 0) that lands in output bit i.
  localparam int FP_TAB [0:63] = '{
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25,
    32, 0, 40,  8, 48, 16, 56, 24
  };

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/des_fp_perm.sv
// Final permutation (IP^-1): pure wiring from the swapped preoutput {R16,L16} to the result block.
module des_fp_perm
  import des_pkg::*;
(
  input  logic [BLOCK_W-1:0] pre_i,
  output logic [BLOCK_W-1:0] fp_o
);

  // Table indices count from the MSB, hence the 63-x mirroring on both sides.
  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign fp_o[BLOCK_W-1-i] = pre_i[BLOCK_W-1-FP_TAB[i]];
  end

endmodule

// File: rtl/des_fp_serializer.sv
// DES output stage: applies FP to {R16,L16}, holds the block and streams it MSB-first in OUT_W-bit beats.
module des_fp_serializer
  import des_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HALF_W-1:0] l16,
  input  logic [HALF_W-1:0] r16,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last
);

  localparam int unsigned NBEATS = BLOCK_W / OUT_W;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  logic [BLOCK_W-1:0] fp;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] hold_q, hold_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;

  logic               beat_hs;
  logic               accept;
  logic [BLOCK_W-1:0] shifted;

  des_fp_perm u_perm (
    .pre_i ({r16, l16}),
    .fp_o  (fp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    beat_hs  = out_valid_q && out_ready;
    // A last-beat handshake frees the holding register in the same cycle, so a new block can slip in.
    in_ready = (state_q == IDLE) || (beat_hs && out_last_q);
    accept   = in_valid && in_ready;

    if (accept) begin
      hold_d  = fp;
      cnt_d   = '0;
      state_d = SEND;
    end else if (beat_hs) begin
      if (out_last_q) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Output registers are loaded from next-state so beats appear one cycle after accept/handshake.
    shifted     = hold_d << (int'(cnt_d) * OUT_W);
    out_valid_d = (state_d == SEND);
    out_last_d  = (state_d == SEND) && (cnt_d == LAST_CNT);
    out_data_d  = (state_d == SEND) ? shifted[BLOCK_W-1 -: OUT_W] : '0;
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_des_fp_serializer.sv
// Directed bench for des_fp_serializer: known answer, backpressure, back-to-back, reset, ignored input, IP round-trip.
module tb_des_fp_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] l16, r16;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] KAT_L = 32'h43423234;
  localparam logic [31:0] KAT_R = 32'h0A4CD995;
  logic [7:0] kat [8] = '{8'h85, 8'hE8, 8'h13, 8'h54, 8'h0F, 8'h0A, 8'hB4, 8'h05};

  always #5 clk = ~clk;

  des_fp_serializer #(.OUT_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .l16       (l16),
    .r16       (r16),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  logic        rt_valid;
  logic [31:0] rt_l, rt_r;
  logic [63:0] rt_res [4];
  int          rt_cnt [4];

  for (genvar g = 0; g < 4; g++) begin : g_rt
    localparam int unsigned W = 8 << g;
    logic         rdy, vld, lst;
    logic [W-1:0] dat;
    logic [63:0]  acc, res;
    int           n;

    des_fp_serializer #(.OUT_W(W)) u_rt (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rt_valid),
      .in_ready  (rdy),
      .l16       (rt_l),
      .r16       (rt_r),
      .out_valid (vld),
      .out_ready (1'b1),
      .out_data  (dat),
      .out_last  (lst)
    );

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc <= '0;
        res <= '0;
        n   <= 0;
      end else if (vld) begin
        if (lst) begin
          res <= (acc << W) | 64'(dat);
          acc <= '0;
          n   <= n + 1;
        end else begin
          acc <= (acc << W) | 64'(dat);
        end
      end
    end

    assign rt_res[g] = res;
    assign rt_cnt[g] = n;
  end

  // Standard DES initial permutation, index 0 = DES bit 1 (MSB).
  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    int r, c, src;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      r = i / 8;
      c = i % 8;
      src = (r < 4) ? (57 + 2 * r - 8 * c) : (56 + 2 * (r - 4) - 8 * c);
      y[63 - i] = x[63 - src];
    end
    return y;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rt_valid = 1'b0;
    l16 = '0; r16 = '0; rt_l = '0; rt_r = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_known_answer();
    @(negedge clk);
    l16 = KAT_L; r16 = KAT_R; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL kat_valid beat %0d got %b want 1", k, out_valid); end
      checks++; if (out_data !== kat[k]) begin errors++; $display("FAIL kat_data beat %0d got %h want %h", k, out_data, kat[k]); end
      checks++; if (out_last !== (k == 7)) begin errors++; $display("FAIL kat_last beat %0d got %b want %b", k, out_last, k == 7); end
      checks++; if (in_ready !== (k == 7)) begin errors++; $display("FAIL kat_in_ready beat %0d got %b want %b", k, in_ready, k == 7); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kat_idle_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL kat_idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int beat = 0;
    int cyc = 0;
    @(negedge clk);
    l16 = KAT_L; r16 = KAT_R; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (beat < 8 && cyc < 64) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %b want 1", cyc, out_valid); end
      checks++; if (out_data !== kat[beat]) begin errors++; $display("FAIL bp_data cyc %0d got %h want %h", cyc, out_data, kat[beat]); end
      checks++; if (out_last !== (beat == 7)) begin errors++; $display("FAIL bp_last cyc %0d got %b want %b", cyc, out_last, beat == 7); end
      out_ready = pat[cyc % 4];
      #1;
      checks++; if (in_ready !== (out_ready && beat == 7)) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want %b", cyc, in_ready, out_ready && beat == 7); end
      if (out_ready) beat++;
      cyc++;
      @(negedge clk);
    end
    checks++; if (beat != 8) begin errors++; $display("FAIL bp_timeout got %0d beats want 8", beat); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_valid got %b want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] xb, ipb;
    logic [7:0]  exp;
    xb  = 64'h0123456789ABCDEF;
    ipb = ip_f(xb);
    @(negedge clk);
    l16 = KAT_L; r16 = KAT_R; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    l16 = ipb[31:0]; r16 = ipb[63:32];
    for (int k = 0; k < 16; k++) begin
      exp = (k < 8) ? kat[k] : xb[63 - 8 * (k - 8) -: 8];
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got %b want 1", k, out_valid); end
      checks++; if (out_data !== exp) begin errors++; $display("FAIL b2b_data beat %0d got %h want %h", k, out_data, exp); end
      checks++; if (out_last !== (k == 7 || k == 15)) begin errors++; $display("FAIL b2b_last beat %0d got %b want %b", k, out_last, k == 7 || k == 15); end
      if (k == 7) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_last got %b want 1", in_ready); end
      end
      if (k == 8) in_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] xr, ipr;
    xr  = 64'hFEDCBA9876543210;
    ipr = ip_f(xr);
    @(negedge clk);
    l16 = KAT_L; r16 = KAT_R; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data !== kat[k]) begin errors++; $display("FAIL rst_pre_data beat %0d got %h want %h", k, out_data, kat[k]); end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h want 00", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_mid_last got %b want 0", out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid got %b want 0", out_valid); end
    l16 = ipr[31:0]; r16 = ipr[63:32]; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_new_valid beat %0d got %b want 1", k, out_valid); end
      checks++; if (out_data !== xr[63 - 8 * k -: 8]) begin errors++; $display("FAIL rst_new_data beat %0d got %h want %h", k, out_data, xr[63 - 8 * k -: 8]); end
      checks++; if (out_last !== (k == 7)) begin errors++; $display("FAIL rst_new_last beat %0d got %b want %b", k, out_last, k == 7); end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_extra_beat cyc %0d got %b want 0", k, out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_input();
    logic [63:0] ipi;
    ipi = ip_f(64'h1122334455667788);
    @(negedge clk);
    l16 = KAT_L; r16 = KAT_R; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ign_valid beat %0d got %b want 1", k, out_valid); end
      checks++; if (out_data !== kat[k]) begin errors++; $display("FAIL ign_data beat %0d got %h want %h", k, out_data, kat[k]); end
      if (k == 2) begin
        l16 = ipi[31:0]; r16 = ipi[63:32]; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ign_in_ready got %b want 0", in_ready); end
      end
      if (k == 3) in_valid = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ign_captured cyc %0d got %b want 0", k, out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_round_trip();
    logic [63:0] x, ipx;
    int base [4];
    int cyc;
    for (int n = 0; n < 1000; n++) begin
      x   = (n == 0) ? 64'h85E813540F0AB405 : {$urandom, $urandom};
      ipx = ip_f(x);
      for (int k = 0; k < 4; k++) base[k] = rt_cnt[k];
      @(negedge clk);
      rt_l = ipx[31:0]; rt_r = ipx[63:32]; rt_valid = 1'b1;
      @(negedge clk);
      rt_valid = 1'b0;
      cyc = 0;
      while ((rt_cnt[0] != base[0] + 1 || rt_cnt[1] != base[1] + 1 ||
              rt_cnt[2] != base[2] + 1 || rt_cnt[3] != base[3] + 1) && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc >= 20) begin
        errors++;
        $display("FAIL rt_timeout block %0d counts %0d %0d %0d %0d", n, rt_cnt[0], rt_cnt[1], rt_cnt[2], rt_cnt[3]);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rt_res[k] !== x) begin
          errors++;
          $display("FAIL rt_data w%0d block %0d got %h want %h", 8 << k, n, rt_res[k], x);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_answer();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_ignored_input();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
